// File: rtl/fc_ec_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fc_ec_stream
// Brief    : Compresses each time step of the pre-synaptic spike RAM into a
//            list of spike addresses, then streams accumulate events and
//            activate pulses to the FC neuron engine. Optional macro
//            FC_EC_OVERLAP_EN lets group-0 issue overlap compression.
// Revision : 1.0 - initial release
// ============================================================================
module fc_ec_stream #(
    parameter int TIME_STEPS       = 10,
    parameter int EC_SIZE          = 4,
    parameter int LAYER_SIZE       = 32,
    parameter int INPUT_CHANNELS   = 2,
    parameter int INPUT_FRAME_SIZE = 120,
    parameter int PENC_SIZE        = 20,
    parameter int SPARSE_SIZE      = INPUT_CHANNELS * INPUT_FRAME_SIZE,
    localparam int NG   = LAYER_SIZE / EC_SIZE,
    localparam int AW   = $clog2(SPARSE_SIZE),
    localparam int CW   = AW + 1,
    localparam int ICW  = $clog2(INPUT_CHANNELS) + 1,
    localparam int TSW  = $clog2(TIME_STEPS) + 1,
    localparam int GW   = $clog2(NG) + 1,
    localparam int TOTW = $clog2(TIME_STEPS * SPARSE_SIZE) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        spk_rd_en,
    output logic [ICW-1:0]              spk_rd_ic,
    output logic [TSW-1:0]              spk_rd_ts,
    input  logic [INPUT_FRAME_SIZE-1:0] spk_rd_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [AW-1:0]               evt_addr,
    output logic [GW-1:0]               evt_group,
    output logic [TSW-1:0]              evt_ts,
    output logic                        activ_valid,
    output logic                        last_time_step,
    output logic                        busy,
    output logic                        done,
    output logic [TOTW-1:0]             layer_spk_total
);

    localparam int c_nch  = (SPARSE_SIZE + PENC_SIZE - 1) / PENC_SIZE;
    localparam int c_padw = c_nch * PENC_SIZE;
    localparam int c_chw  = $clog2(c_nch) + 1;
    localparam int c_pw   = $clog2(PENC_SIZE) + 1;
    localparam int c_tsiw = $clog2(TIME_STEPS);
    localparam int c_memd = TIME_STEPS * SPARSE_SIZE;
    localparam int c_maw  = $clog2(c_memd);

    localparam logic [ICW-1:0]   c_ic_end   = ICW'(INPUT_CHANNELS);
    localparam logic [TSW-1:0]   c_ts_last  = TSW'(TIME_STEPS - 1);
    localparam logic [TSW-1:0]   c_ts_all   = TSW'(TIME_STEPS);
    localparam logic [c_chw-1:0] c_ci_last  = c_chw'(c_nch - 1);
    localparam logic [GW-1:0]    c_grp_last = GW'(NG - 1);

    typedef enum logic [2:0] {
        CS_IDLE, CS_READ, CS_CHUNK_LOAD, CS_CHUNK_SCAN, CS_TS_NEXT, CS_CDONE
    } cstate_t;

    typedef enum logic [2:0] {
        IS_IDLE, IS_ISSUE, IS_ACTIV, IS_TS_NEXT, IS_GRP_NEXT, IS_DONE
    } istate_t;

    cstate_t r_c_state, w_c_next;
    istate_t r_i_state, w_i_next;

    logic                 w_start;
    logic                 w_busy;
    logic [ICW-1:0]       r_ic;
    logic [ICW-1:0]       r_rd_ic_q;
    logic                 r_rd_pend;
    logic [TSW-1:0]       r_ts;
    logic [TSW-1:0]       r_lat;
    logic [c_padw-1:0]    r_frame;
    logic [PENC_SIZE-1:0] r_chunk;
    logic [c_chw-1:0]     r_ci;
    logic [c_pw-1:0]      w_low;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        r_ts_count [TIME_STEPS];
    logic [TOTW-1:0]      r_total;
    logic [AW-1:0]        r_mem [c_memd];
    logic                 w_we;
    logic [c_maw-1:0]     w_widx;
    logic [c_maw-1:0]     w_ridx;
    logic [AW-1:0]        w_waddr;
    logic [GW-1:0]        r_grp;
    logic [TSW-1:0]       r_i_ts;
    logic [CW-1:0]        r_k;
    logic [CW-1:0]        w_cur_cnt;
    logic                 w_ts_avail;
    logic                 w_evt_valid;

    assign w_busy  = (r_i_state != IS_IDLE) && (r_i_state != IS_DONE);
    assign w_start = start && !w_busy;

    // ------------------------------------------------------------------
    // Compression
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_c_state <= CS_IDLE;
        else     r_c_state <= w_c_next;
    end

    always_comb begin
        w_c_next = r_c_state;
        case (r_c_state)
            CS_IDLE, CS_CDONE: if (w_start) w_c_next = CS_READ;
            CS_READ:           if (r_ic == c_ic_end) w_c_next = CS_CHUNK_LOAD;
            CS_CHUNK_LOAD:     w_c_next = CS_CHUNK_SCAN;
            CS_CHUNK_SCAN:
                if (r_chunk == '0)
                    w_c_next = (r_ci == c_ci_last) ? CS_TS_NEXT : CS_CHUNK_LOAD;
            CS_TS_NEXT:        w_c_next = (r_ts == c_ts_last) ? CS_CDONE : CS_READ;
            default:           w_c_next = CS_IDLE;
        endcase
    end

    always_comb begin
        w_low = '0;
        for (int i = PENC_SIZE - 1; i >= 0; i--)
            if (r_chunk[i]) w_low = c_pw'(i);
    end

    assign spk_rd_en = (r_c_state == CS_READ) && (r_ic != c_ic_end);
    assign spk_rd_ic = r_ic;
    assign spk_rd_ts = r_ts;
    assign w_we      = (r_c_state == CS_CHUNK_SCAN) && (r_chunk != '0);
    assign w_waddr   = AW'(r_ci * PENC_SIZE) + AW'(w_low);
    assign w_widx    = c_maw'(r_ts * SPARSE_SIZE) + c_maw'(r_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ic      <= '0;
            r_rd_ic_q <= '0;
            r_rd_pend <= 1'b0;
            r_ts      <= '0;
            r_lat     <= '0;
            r_frame   <= '0;
            r_chunk   <= '0;
            r_ci      <= '0;
            r_cnt     <= '0;
            r_total   <= '0;
            for (int t = 0; t < TIME_STEPS; t++) r_ts_count[t] <= '0;
        end else begin
            r_rd_pend <= spk_rd_en;
            r_rd_ic_q <= r_ic;
            // Word ic lands one cycle after its strobe; ic0 fills the LSBs
            if (r_rd_pend)
                r_frame[r_rd_ic_q * INPUT_FRAME_SIZE +: INPUT_FRAME_SIZE] <= spk_rd_data;
            case (r_c_state)
                CS_IDLE, CS_CDONE: begin
                    if (w_start) begin
                        r_ts    <= '0;
                        r_ic    <= '0;
                        r_ci    <= '0;
                        r_cnt   <= '0;
                        r_lat   <= '0;
                        r_total <= '0;
                        for (int t = 0; t < TIME_STEPS; t++) r_ts_count[t] <= '0;
                    end
                end
                CS_READ: begin
                    if (r_ic != c_ic_end) r_ic <= r_ic + 1'b1;
                end
                CS_CHUNK_LOAD: begin
                    r_chunk <= r_frame[r_ci * PENC_SIZE +: PENC_SIZE];
                end
                CS_CHUNK_SCAN: begin
                    if (r_chunk != '0) begin
                        r_chunk <= r_chunk & (r_chunk - 1'b1);
                        r_cnt   <= r_cnt + 1'b1;
                    end else if (r_ci != c_ci_last) begin
                        r_ci <= r_ci + 1'b1;
                    end else begin
                        r_ci <= '0;
                    end
                end
                CS_TS_NEXT: begin
                    r_ts_count[r_ts[c_tsiw-1:0]] <= r_cnt;
                    r_total <= r_total + TOTW'(r_cnt);
                    r_lat   <= r_ts + 1'b1;
                    r_cnt   <= '0;
                    r_ic    <= '0;
                    if (r_ts != c_ts_last) r_ts <= r_ts + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_widx] <= w_waddr;
    end

    assign layer_spk_total = r_total;

    // ------------------------------------------------------------------
    // Event issue
    // ------------------------------------------------------------------
`ifdef FC_EC_OVERLAP_EN
    assign w_ts_avail = (r_i_ts < r_lat);
`else
    assign w_ts_avail = (r_lat == c_ts_all);
`endif

    assign w_cur_cnt = r_ts_count[r_i_ts[c_tsiw-1:0]];
    assign w_ridx    = c_maw'(r_i_ts * SPARSE_SIZE) + c_maw'(r_k);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_i_state <= IS_IDLE;
        else     r_i_state <= w_i_next;
    end

    always_comb begin
        w_i_next       = r_i_state;
        w_evt_valid    = 1'b0;
        activ_valid    = 1'b0;
        last_time_step = 1'b0;
        done           = 1'b0;
        busy           = w_busy;
        case (r_i_state)
            IS_IDLE: if (w_start) w_i_next = IS_ISSUE;
            IS_ISSUE: begin
                if (w_ts_avail) begin
                    if (w_cur_cnt == '0) begin
                        w_i_next = IS_ACTIV;
                    end else begin
                        w_evt_valid = 1'b1;
                        if (evt_ready && (r_k == w_cur_cnt - 1'b1)) w_i_next = IS_ACTIV;
                    end
                end
            end
            IS_ACTIV: begin
                activ_valid    = 1'b1;
                last_time_step = (r_i_ts == c_ts_last);
                w_i_next       = IS_TS_NEXT;
            end
            IS_TS_NEXT:  w_i_next = (r_i_ts == c_ts_last) ? IS_GRP_NEXT : IS_ISSUE;
            IS_GRP_NEXT: w_i_next = (r_grp == c_grp_last) ? IS_DONE : IS_ISSUE;
            IS_DONE: begin
                done = 1'b1;
                if (w_start) w_i_next = IS_ISSUE;
            end
            default: w_i_next = IS_IDLE;
        endcase
    end

    assign evt_valid = w_evt_valid;
    assign evt_addr  = w_evt_valid ? r_mem[w_ridx] : '0;
    assign evt_group = r_grp;
    assign evt_ts    = r_i_ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grp  <= '0;
            r_i_ts <= '0;
            r_k    <= '0;
        end else begin
            case (r_i_state)
                IS_IDLE, IS_DONE: begin
                    if (w_start) begin
                        r_grp  <= '0;
                        r_i_ts <= '0;
                        r_k    <= '0;
                    end
                end
                IS_ISSUE: if (w_evt_valid && evt_ready) r_k <= r_k + 1'b1;
                IS_TS_NEXT: begin
                    r_k <= '0;
                    if (r_i_ts != c_ts_last) r_i_ts <= r_i_ts + 1'b1;
                end
                IS_GRP_NEXT: begin
                    r_i_ts <= '0;
                    if (r_grp != c_grp_last) r_grp <= r_grp + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_ec_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fc_ec_stream
// Brief    : Scoreboard bench for fc_ec_stream with a spike-RAM model and a
//            reference event/activate list built from the RAM contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_ec_stream;

    localparam int TS   = 10;
    localparam int EC   = 4;
    localparam int LS   = 32;
    localparam int IC   = 2;
    localparam int IFS  = 120;
    localparam int PENC = 20;
    localparam int SS   = IC * IFS;
    localparam int NG   = LS / EC;
    localparam int NCH  = (SS + PENC - 1) / PENC;
    localparam int AW   = $clog2(SS);
    localparam int ICW  = $clog2(IC) + 1;
    localparam int TSW  = $clog2(TS) + 1;
    localparam int GW   = $clog2(NG) + 1;
    localparam int TOTW = $clog2(TS * SS) + 1;
    localparam int BOUND = 40000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            spk_rd_en;
    logic [ICW-1:0]  spk_rd_ic;
    logic [TSW-1:0]  spk_rd_ts;
    logic [IFS-1:0]  spk_rd_data;
    logic            evt_valid;
    logic            evt_ready;
    logic [AW-1:0]   evt_addr;
    logic [GW-1:0]   evt_group;
    logic [TSW-1:0]  evt_ts;
    logic            activ_valid;
    logic            last_time_step;
    logic            busy;
    logic            done;
    logic [TOTW-1:0] layer_spk_total;

    fc_ec_stream #(
        .TIME_STEPS(TS), .EC_SIZE(EC), .LAYER_SIZE(LS), .INPUT_CHANNELS(IC),
        .INPUT_FRAME_SIZE(IFS), .PENC_SIZE(PENC), .SPARSE_SIZE(SS)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .spk_rd_en(spk_rd_en), .spk_rd_ic(spk_rd_ic), .spk_rd_ts(spk_rd_ts),
        .spk_rd_data(spk_rd_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_addr(evt_addr),
        .evt_group(evt_group), .evt_ts(evt_ts),
        .activ_valid(activ_valid), .last_time_step(last_time_step),
        .busy(busy), .done(done), .layer_spk_total(layer_spk_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_act;
        int addr;
        int grp;
        int ts;
        bit last;
    } rec_t;

    rec_t           exp_q[$];
    logic [IFS-1:0] ram [TS][IC];
    int             n_cmp = 0;
    int             n_fail = 0;
    int             act_cnt, last_cnt, evt_seen;
    bit             stall_en = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Spike RAM: data one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        if (spk_rd_en) spk_rd_data <= ram[spk_rd_ts[3:0]][spk_rd_ic[0]];
        else           spk_rd_data <= IFS'({$urandom, $urandom, $urandom, $urandom});
    end

    initial begin
        int stall;
        stall = 0;
        evt_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!stall_en) begin
                evt_ready = 1'b1;
            end else if (stall > 0) begin
                evt_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 3) == 0) begin
                evt_ready = 1'b0;
                stall = $urandom_range(0, 4);
            end else begin
                evt_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the expected stream on every handshake or activate
    rec_t            e;
    bit              pv, pr;
    logic [AW-1:0]   pa;
    logic [GW-1:0]   pg;
    logic [TSW-1:0]  pt;

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("evt_valid held", evt_valid, 1);
                check("evt_addr held", evt_addr, pa);
                check("evt_group held", evt_group, pg);
                check("evt_ts held", evt_ts, pt);
            end
            if (evt_valid || activ_valid)
                check("evt/activ exclusive", evt_valid & activ_valid, 0);
            if (last_time_step && !activ_valid)
                check("last_time_step without activ", last_time_step, 0);
            if (evt_valid && evt_ready) begin
                evt_seen++;
                if (exp_q.size() == 0) begin
                    check("event with empty queue, depth", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("order (1=activ) at event", 0, e.is_act);
                    check("evt_addr", evt_addr, e.addr);
                    check("evt_group", evt_group, e.grp);
                    check("evt_ts", evt_ts, e.ts);
                end
            end
            if (activ_valid) begin
                act_cnt++;
                if (last_time_step) last_cnt++;
                if (exp_q.size() == 0) begin
                    check("activ with empty queue, depth", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("order (1=activ) at activ", 1, e.is_act);
                    check("activ group", evt_group, e.grp);
                    check("activ ts", evt_ts, e.ts);
                    check("last_time_step", last_time_step, e.last);
                end
            end
            pv = evt_valid;
            pr = evt_ready;
            pa = evt_addr;
            pg = evt_group;
            pt = evt_ts;
        end
    end

    // Reference: spike address a of step t is bit a%IFS of word a/IFS
    task automatic build_expected(output int total);
        rec_t r;
        total = 0;
        for (int t = 0; t < TS; t++)
            for (int a = 0; a < SS; a++)
                if (ram[t][a / IFS][a % IFS]) total++;
        for (int g = 0; g < NG; g++) begin
            for (int t = 0; t < TS; t++) begin
                for (int a = 0; a < SS; a++) begin
                    if (ram[t][a / IFS][a % IFS]) begin
                        r.is_act = 1'b0; r.addr = a; r.grp = g; r.ts = t; r.last = 1'b0;
                        exp_q.push_back(r);
                    end
                end
                r.is_act = 1'b1; r.addr = 0; r.grp = g; r.ts = t; r.last = (t == TS - 1);
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic fill_zero();
        for (int t = 0; t < TS; t++)
            for (int c = 0; c < IC; c++) ram[t][c] = '0;
    endtask

    task automatic fill_rand(input int dens);
        for (int t = 0; t < TS; t++)
            for (int c = 0; c < IC; c++)
                for (int b = 0; b < IFS; b++)
                    ram[t][c][b] = ($urandom_range(0, 99) < dens);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " all outputs zero"},
              {spk_rd_en, spk_rd_ic, spk_rd_ts, evt_valid, evt_addr, evt_group, evt_ts,
               activ_valid, last_time_step, busy, done, layer_spk_total}, 0);
    endtask

    task automatic run_image(input string tag, input bit chk_lat, input bit extra_start);
        int total, cyc, first, lat_bound;
        exp_q.delete();
        build_expected(total);
        act_cnt = 0; last_cnt = 0; evt_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; first = -1;
        while (!done && cyc < BOUND) begin
            if (evt_valid && first < 0) first = cyc;
            start = extra_start && (cyc == 50);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, " completes"}, cyc < BOUND, 1);
        check({tag, " leftover expected records"}, exp_q.size(), 0);
        check({tag, " layer_spk_total"}, layer_spk_total, total);
        check({tag, " activ pulses"}, act_cnt, NG * TS);
        check({tag, " last_time_step pulses"}, last_cnt, NG);
        check({tag, " done"}, done, 1);
        check({tag, " busy"}, busy, 0);
        if (chk_lat) begin
            // Lower bound on a full compression pass of the image
            lat_bound = TS * (IC + 2 + 2 * NCH) + total;
`ifdef FC_EC_OVERLAP_EN
            check({tag, " first event overlaps compression"}, first < lat_bound, 1);
`else
            check({tag, " first event after compression"}, first >= lat_bound, 1);
`endif
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int total, cyc;
        rst = 1'b1;
        start = 1'b0;
        fill_zero();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("in reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("after reset");
        @(posedge clk); #1;

        fill_zero();
        run_image("all zero", 1'b0, 1'b0);

        fill_zero();
        ram[3][1][119] = 1'b1;
        run_image("single ts3 addr239", 1'b0, 1'b0);

        fill_zero();
        ram[0][0] = '1;
        ram[0][1] = '1;
        run_image("ts0 all ones", 1'b1, 1'b0);

        stall_en = 1'b1;
        fill_rand(5);
        run_image("random 5pct stalls", 1'b0, 1'b0);
        fill_rand(20);
        run_image("random 20pct stalls + busy start", 1'b0, 1'b1);

        // Reset in the middle of event issue, then a clean rerun
        fill_rand(10);
        exp_q.delete();
        build_expected(total);
        evt_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (evt_seen < 20 && cyc < BOUND) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reached mid-issue", evt_seen >= 20, 1);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid-issue reset");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("idle after abort");
        run_image("rerun after reset", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
